// File: rtl/frame_buffer_pkg.sv
// frame_buffer_pkg
// Shared definitions for the frame buffer path: default pixel address/data
// widths, the active VGA raster size, the frame buffer command record and
// the encoding of the arbiter's round-robin "last served" flag.
package frame_buffer_pkg;

    localparam int COL_W    = 10;
    localparam int ROW_W    = 9;
    localparam int PIX_W    = 24;
    localparam int VGA_HACT = 640;
    localparam int VGA_VACT = 480;

    typedef struct packed {
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
        logic [PIX_W-1:0] pixel;
        logic             we;
        logic             re;
    } fb_cmd_t;

    // Round-robin memory of which requester won the last contended cycle.
    localparam logic SRC_W = 1'b0;
    localparam logic SRC_R = 1'b1;

endpackage

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo
// Synchronous FIFO holding converter writes until the arbiter serves them.
// Not fall-through: an entry pushed at an edge is poppable from the next cycle.
// A push while full is accepted only when a pop happens in the same cycle.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, din         write request and entry
//   pop               remove head entry (ignored when empty)
//   dout              head entry (valid when !empty)
//   level             occupancy, 0..DEPTH
//   full, empty       occupancy flags
module fb_wr_fifo #(
    parameter int WIDTH = 43,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign pop_ok  = pop & ~empty;
    // When full, the slot being popped this cycle is the one the push reuses.
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rd_ptr_reg];

    // Storage is not reset: contents are meaningless once the pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level      <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter
// Shares the single-port frame buffer between the colorspace converter's
// write stream (buffered in fb_wr_fifo, never stalled) and Sobel window-fetch
// reads. One command per cycle; contended cycles alternate round-robin.
// Read data returns 2+FB_RD_LAT cycles after the grant.
// Optional macro FB_ARB_WR_URGENT_EN: when the write FIFO holds at least
// WR_FIFO_DEPTH-1 entries, writes win every cycle regardless of round-robin.
// Ports:
//   I_CLK, I_RESET                      clock, asynchronous active-high reset
//   I_WR_VALID/COL/ROW/PIXEL            converter write pulse
//   I_RD_REQ/COL/ROW, O_RD_GNT          read request held until granted
//   O_RD_VALID, O_RD_PIXEL              read return
//   O_FB_COL/ROW/PIXEL, O_FB_WE/RE      registered frame buffer command
//   I_FB_PIXEL                          frame buffer read data
//   O_WR_LEVEL, O_WR_OVERFLOW           FIFO occupancy, sticky drop flag
module frame_buffer_arbiter #(
    parameter int COL_W         = frame_buffer_pkg::COL_W,
    parameter int ROW_W         = frame_buffer_pkg::ROW_W,
    parameter int PIX_W         = frame_buffer_pkg::PIX_W,
    parameter int WR_FIFO_DEPTH = 4,
    parameter int FB_RD_LAT     = 1
) (
    input  logic                             I_CLK,
    input  logic                             I_RESET,
    input  logic                             I_WR_VALID,
    input  logic [COL_W-1:0]                 I_WR_COL,
    input  logic [ROW_W-1:0]                 I_WR_ROW,
    input  logic [PIX_W-1:0]                 I_WR_PIXEL,
    input  logic                             I_RD_REQ,
    input  logic [COL_W-1:0]                 I_RD_COL,
    input  logic [ROW_W-1:0]                 I_RD_ROW,
    output logic                             O_RD_GNT,
    output logic                             O_RD_VALID,
    output logic [PIX_W-1:0]                 O_RD_PIXEL,
    output logic [COL_W-1:0]                 O_FB_COL,
    output logic [ROW_W-1:0]                 O_FB_ROW,
    output logic [PIX_W-1:0]                 O_FB_PIXEL,
    output logic                             O_FB_WE,
    output logic                             O_FB_RE,
    input  logic [PIX_W-1:0]                 I_FB_PIXEL,
    output logic [$clog2(WR_FIFO_DEPTH):0]   O_WR_LEVEL,
    output logic                             O_WR_OVERFLOW
);

    import frame_buffer_pkg::*;

    localparam int ENT_W = COL_W + ROW_W + PIX_W;

    logic [ENT_W-1:0]     wr_entry;
    logic [ENT_W-1:0]     head;
    logic [COL_W-1:0]     head_col;
    logic [ROW_W-1:0]     head_row;
    logic [PIX_W-1:0]     head_pixel;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 w_cand;
    logic                 r_cand;
    logic                 contended;
    logic                 urgent;
    logic                 serve_r;
    logic                 serve_w;
    logic                 last_served_reg;
    logic [FB_RD_LAT-1:0] rd_pipe_reg;

    assign wr_entry = {I_WR_COL, I_WR_ROW, I_WR_PIXEL};
    assign {head_col, head_row, head_pixel} = head;

    fb_wr_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (WR_FIFO_DEPTH)
    ) u_wr_fifo (
        .clk   (I_CLK),
        .rst   (I_RESET),
        .push  (I_WR_VALID),
        .pop   (serve_w),
        .din   (wr_entry),
        .dout  (head),
        .level (O_WR_LEVEL),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign w_cand    = ~fifo_empty;
    assign r_cand    = I_RD_REQ;
    assign contended = w_cand & r_cand;

`ifdef FB_ARB_WR_URGENT_EN
    assign urgent = (O_WR_LEVEL >= ($clog2(WR_FIFO_DEPTH)+1)'(WR_FIFO_DEPTH - 1));
`else
    assign urgent = 1'b0;
`endif

    // Reset gating keeps the combinational grant low while I_RESET is high.
    assign serve_r  = ~I_RESET & r_cand &
                      (~w_cand | ((last_served_reg == SRC_W) & ~urgent));
    assign serve_w  = ~I_RESET & w_cand & ~serve_r;
    assign O_RD_GNT = serve_r;

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            last_served_reg <= SRC_W;
            O_FB_COL        <= '0;
            O_FB_ROW        <= '0;
            O_FB_PIXEL      <= '0;
            O_FB_WE         <= 1'b0;
            O_FB_RE         <= 1'b0;
            rd_pipe_reg     <= '0;
            O_RD_VALID      <= 1'b0;
            O_RD_PIXEL      <= '0;
            O_WR_OVERFLOW   <= 1'b0;
        end else begin
            // Round-robin memory only moves when both requesters competed.
            if (contended) begin
                last_served_reg <= serve_r ? SRC_R : SRC_W;
            end

            O_FB_WE <= serve_w;
            O_FB_RE <= serve_r;
            if (serve_r) begin
                O_FB_COL <= I_RD_COL;
                O_FB_ROW <= I_RD_ROW;
            end else if (serve_w) begin
                O_FB_COL   <= head_col;
                O_FB_ROW   <= head_row;
                O_FB_PIXEL <= head_pixel;
            end

            // Tracks issued reads until the frame buffer's data is due.
            rd_pipe_reg[0] <= O_FB_RE;
            for (int i = 1; i < FB_RD_LAT; i++) begin
                rd_pipe_reg[i] <= rd_pipe_reg[i-1];
            end
            O_RD_VALID <= rd_pipe_reg[FB_RD_LAT-1];
            if (rd_pipe_reg[FB_RD_LAT-1]) begin
                O_RD_PIXEL <= I_FB_PIXEL;
            end

            if (I_WR_VALID & fifo_full & ~serve_w) begin
                O_WR_OVERFLOW <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb_frame_buffer_arbiter
// Directed bench for frame_buffer_arbiter with a behavioural frame buffer
// (one-cycle read latency). Expected values are hand-derived per cycle.
// Honours FB_ARB_WR_URGENT_EN to select the matching expectation tables.
module tb_frame_buffer_arbiter;

    localparam int COL_W = 10;
    localparam int ROW_W = 9;
    localparam int PIX_W = 24;

`ifdef FB_ARB_WR_URGENT_EN
    localparam logic [7:0] RR_GNT     = 8'h0B;
    localparam int         RR_LVL [13] = '{0, 1, 2, 2, 3, 3, 3, 3, 3, 2, 1, 0, 0};
    localparam int         RR_OVF_AT  = 99;
    localparam int         RR_NWR     = 8;
`else
    localparam logic [7:0] RR_GNT     = 8'hAB;
    localparam int         RR_LVL [13] = '{0, 1, 2, 2, 3, 3, 4, 4, 4, 3, 2, 1, 0};
    localparam int         RR_OVF_AT  = 8;
    localparam int         RR_NWR     = 7;
`endif

    logic             I_CLK = 1'b0;
    logic             I_RESET = 1'b1;
    logic             I_WR_VALID = 1'b0;
    logic [COL_W-1:0] I_WR_COL = '0;
    logic [ROW_W-1:0] I_WR_ROW = '0;
    logic [PIX_W-1:0] I_WR_PIXEL = '0;
    logic             I_RD_REQ = 1'b0;
    logic [COL_W-1:0] I_RD_COL = '0;
    logic [ROW_W-1:0] I_RD_ROW = '0;
    logic             O_RD_GNT;
    logic             O_RD_VALID;
    logic [PIX_W-1:0] O_RD_PIXEL;
    logic [COL_W-1:0] O_FB_COL;
    logic [ROW_W-1:0] O_FB_ROW;
    logic [PIX_W-1:0] O_FB_PIXEL;
    logic             O_FB_WE;
    logic             O_FB_RE;
    logic [PIX_W-1:0] I_FB_PIXEL = '0;
    logic [2:0]       O_WR_LEVEL;
    logic             O_WR_OVERFLOW;

    int checks = 0;
    int failures = 0;

    frame_buffer_arbiter dut (
        .I_CLK         (I_CLK),
        .I_RESET       (I_RESET),
        .I_WR_VALID    (I_WR_VALID),
        .I_WR_COL      (I_WR_COL),
        .I_WR_ROW      (I_WR_ROW),
        .I_WR_PIXEL    (I_WR_PIXEL),
        .I_RD_REQ      (I_RD_REQ),
        .I_RD_COL      (I_RD_COL),
        .I_RD_ROW      (I_RD_ROW),
        .O_RD_GNT      (O_RD_GNT),
        .O_RD_VALID    (O_RD_VALID),
        .O_RD_PIXEL    (O_RD_PIXEL),
        .O_FB_COL      (O_FB_COL),
        .O_FB_ROW      (O_FB_ROW),
        .O_FB_PIXEL    (O_FB_PIXEL),
        .O_FB_WE       (O_FB_WE),
        .O_FB_RE       (O_FB_RE),
        .I_FB_PIXEL    (I_FB_PIXEL),
        .O_WR_LEVEL    (O_WR_LEVEL),
        .O_WR_OVERFLOW (O_WR_OVERFLOW)
    );

    always #5 I_CLK = ~I_CLK;

    // Behavioural frame buffer: commands sampled mid-cycle, read data
    // presented one cycle after O_FB_RE.
    logic [PIX_W-1:0] fb_mem [int];
    logic [PIX_W-1:0] wr_log [$];
    logic             mdl_re = 1'b0;
    int               mdl_addr = 0;

    always @(negedge I_CLK) begin
        mdl_re   = O_FB_RE;
        mdl_addr = int'({O_FB_ROW, O_FB_COL});
        if (O_FB_WE) begin
            fb_mem[int'({O_FB_ROW, O_FB_COL})] = O_FB_PIXEL;
            wr_log.push_back(O_FB_PIXEL);
            $display("fb write col=%0d row=%0d pixel=%06h", O_FB_COL, O_FB_ROW, O_FB_PIXEL);
        end
    end

    always @(posedge I_CLK) begin
        if (mdl_re) begin
            I_FB_PIXEL <= fb_mem.exists(mdl_addr) ? fb_mem[mdl_addr] : '0;
        end
    end

    task automatic step();
        @(posedge I_CLK);
        #1;
    endtask

    task automatic clear_inputs();
        I_WR_VALID = 1'b0;
        I_WR_COL   = '0;
        I_WR_ROW   = '0;
        I_WR_PIXEL = '0;
        I_RD_REQ   = 1'b0;
        I_RD_COL   = '0;
        I_RD_ROW   = '0;
    endtask

    // Leaves time 1ns after the first edge following release ("cycle 0").
    task automatic do_reset();
        clear_inputs();
        I_RESET = 1'b1;
        repeat (2) @(posedge I_CLK);
        #1;
        I_RESET = 1'b0;
        wr_log.delete();
    endtask

    task automatic test_reset();
        clear_inputs();
        I_RESET    = 1'b1;
        I_RD_REQ   = 1'b1;
        I_WR_VALID = 1'b1;
        repeat (2) @(posedge I_CLK);
        #2;
        checks++; if (O_RD_GNT !== 1'b0) begin failures++; $display("FAIL rst_gnt: got %0b want 0", O_RD_GNT); end
        checks++; if (O_FB_WE !== 1'b0 || O_FB_RE !== 1'b0) begin failures++; $display("FAIL rst_strobes: got we=%0b re=%0b want 0/0", O_FB_WE, O_FB_RE); end
        checks++; if (O_RD_VALID !== 1'b0) begin failures++; $display("FAIL rst_rd_valid: got %0b want 0", O_RD_VALID); end
        checks++; if (O_WR_LEVEL !== 3'd0) begin failures++; $display("FAIL rst_level: got %0d want 0", O_WR_LEVEL); end
        checks++; if (O_WR_OVERFLOW !== 1'b0) begin failures++; $display("FAIL rst_ovf: got %0b want 0", O_WR_OVERFLOW); end
        checks++; if (O_FB_COL !== '0 || O_FB_ROW !== '0 || O_FB_PIXEL !== '0 || O_RD_PIXEL !== '0) begin failures++; $display("FAIL rst_data: got col=%0d row=%0d pix=%0h rd=%0h want 0", O_FB_COL, O_FB_ROW, O_FB_PIXEL, O_RD_PIXEL); end
        clear_inputs();
    endtask

    task automatic test_isolated_read();
        do_reset();
        fb_mem[7*1024 + 5] = 24'hABCDEF;
        I_RD_REQ = 1'b1; I_RD_COL = 10'd5; I_RD_ROW = 9'd7;
        #1;
        checks++; if (O_RD_GNT !== 1'b1) begin failures++; $display("FAIL iso_gnt: got %0b want 1", O_RD_GNT); end
        step();
        I_RD_REQ = 1'b0;
        #1;
        checks++; if (O_FB_RE !== 1'b1 || O_FB_WE !== 1'b0) begin failures++; $display("FAIL iso_fb_re: got re=%0b we=%0b want 1/0", O_FB_RE, O_FB_WE); end
        checks++; if (O_FB_COL !== 10'd5 || O_FB_ROW !== 9'd7) begin failures++; $display("FAIL iso_addr: got (%0d,%0d) want (5,7)", O_FB_COL, O_FB_ROW); end
        step();
        checks++; if (O_RD_VALID !== 1'b0) begin failures++; $display("FAIL iso_early_valid: got %0b want 0", O_RD_VALID); end
        step();
        checks++; if (O_RD_VALID !== 1'b1 || O_RD_PIXEL !== 24'hABCDEF) begin failures++; $display("FAIL iso_return: got v=%0b pix=%06h want 1/abcdef", O_RD_VALID, O_RD_PIXEL); end
        $display("read (5,7) returned %06h", O_RD_PIXEL);
        step();
        checks++; if (O_RD_VALID !== 1'b0) begin failures++; $display("FAIL iso_pulse: got %0b want 0", O_RD_VALID); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        fb_mem[2*1024 + 1] = 24'h111111;
        fb_mem[4*1024 + 3] = 24'h222222;
        I_RD_REQ = 1'b1; I_RD_COL = 10'd1; I_RD_ROW = 9'd2;
        #1;
        checks++; if (O_RD_GNT !== 1'b1) begin failures++; $display("FAIL b2b_gnt0: got %0b want 1", O_RD_GNT); end
        step();
        I_RD_COL = 10'd3; I_RD_ROW = 9'd4;
        #1;
        checks++; if (O_RD_GNT !== 1'b1 || O_FB_RE !== 1'b1 || O_FB_COL !== 10'd1) begin failures++; $display("FAIL b2b_cmd0: got gnt=%0b re=%0b col=%0d want 1/1/1", O_RD_GNT, O_FB_RE, O_FB_COL); end
        step();
        I_RD_REQ = 1'b0;
        #1;
        checks++; if (O_FB_RE !== 1'b1 || O_FB_COL !== 10'd3 || O_FB_ROW !== 9'd4) begin failures++; $display("FAIL b2b_cmd1: got re=%0b (%0d,%0d) want 1 (3,4)", O_FB_RE, O_FB_COL, O_FB_ROW); end
        step();
        checks++; if (O_RD_VALID !== 1'b1 || O_RD_PIXEL !== 24'h111111) begin failures++; $display("FAIL b2b_ret0: got v=%0b pix=%06h want 1/111111", O_RD_VALID, O_RD_PIXEL); end
        step();
        checks++; if (O_RD_VALID !== 1'b1 || O_RD_PIXEL !== 24'h222222) begin failures++; $display("FAIL b2b_ret1: got v=%0b pix=%06h want 1/222222", O_RD_VALID, O_RD_PIXEL); end
        step();
        checks++; if (O_RD_VALID !== 1'b0) begin failures++; $display("FAIL b2b_end: got %0b want 0", O_RD_VALID); end
    endtask

    // Continuous reads and writes for 8 cycles, then drain.
    task automatic test_round_robin();
        logic [7:0] gnt_pat;
        logic       exp_g;
        logic       prev_g;
        gnt_pat = RR_GNT;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            I_WR_VALID = (c < 8);
            I_WR_COL   = COL_W'(c);
            I_WR_ROW   = 9'd1;
            I_WR_PIXEL = PIX_W'(c);
            I_RD_REQ   = (c < 8);
            I_RD_COL   = COL_W'(100 + c);
            I_RD_ROW   = 9'd3;
            #1;
            exp_g = (c < 8) ? gnt_pat[c] : 1'b0;
            checks++; if (O_RD_GNT !== exp_g) begin failures++; $display("FAIL rr_gnt c%0d: got %0b want %0b", c, O_RD_GNT, exp_g); end
            checks++; if (int'(O_WR_LEVEL) != RR_LVL[c]) begin failures++; $display("FAIL rr_level c%0d: got %0d want %0d", c, O_WR_LEVEL, RR_LVL[c]); end
            checks++; if (O_WR_OVERFLOW !== (c >= RR_OVF_AT)) begin failures++; $display("FAIL rr_ovf c%0d: got %0b want %0b", c, O_WR_OVERFLOW, (c >= RR_OVF_AT)); end
            if (c >= 1 && c <= 8) begin
                prev_g = gnt_pat[c-1];
                checks++; if (O_FB_RE !== prev_g || O_FB_WE !== ~prev_g) begin failures++; $display("FAIL rr_cmd c%0d: got re=%0b we=%0b want re=%0b we=%0b", c, O_FB_RE, O_FB_WE, prev_g, ~prev_g); end
            end
            step();
        end
        clear_inputs();
        step();
        checks++; if (wr_log.size() != RR_NWR) begin failures++; $display("FAIL rr_write_count: got %0d want %0d", wr_log.size(), RR_NWR); end
        for (int i = 0; i < wr_log.size() && i < RR_NWR; i++) begin
            checks++; if (wr_log[i] !== PIX_W'(i)) begin failures++; $display("FAIL rr_write_order %0d: got %0h want %0h", i, wr_log[i], i); end
        end
    endtask

`ifdef FB_ARB_WR_URGENT_EN
    // 50% write rate against continuous reads must never overflow.
    task automatic test_urgent_rate();
        do_reset();
        for (int c = 0; c < 100; c++) begin
            I_WR_VALID = (c % 2 == 0);
            I_WR_PIXEL = PIX_W'(c);
            I_RD_REQ   = 1'b1;
            #1;
            if (c % 10 == 9) begin
                checks++; if (O_WR_LEVEL > 3'd3) begin failures++; $display("FAIL urg_level c%0d: got %0d want <=3", c, O_WR_LEVEL); end
            end
            step();
        end
        clear_inputs();
        checks++; if (O_WR_OVERFLOW !== 1'b0) begin failures++; $display("FAIL urg_ovf: got %0b want 0", O_WR_OVERFLOW); end
    endtask
`else
    // Fill to 4 with contended traffic, then push and pop in one cycle.
    task automatic test_full_push_pop();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            I_WR_VALID = 1'b1; I_WR_PIXEL = PIX_W'(c); I_RD_REQ = 1'b1;
            step();
        end
        I_WR_VALID = 1'b1; I_WR_PIXEL = 24'h0000AA; I_RD_REQ = 1'b1;
        #1;
        checks++; if (O_WR_LEVEL !== 3'd4 || O_RD_GNT !== 1'b0) begin failures++; $display("FAIL fpp_pre: got level=%0d gnt=%0b want 4/0", O_WR_LEVEL, O_RD_GNT); end
        step();
        clear_inputs();
        #1;
        checks++; if (O_WR_LEVEL !== 3'd4) begin failures++; $display("FAIL fpp_level: got %0d want 4", O_WR_LEVEL); end
        checks++; if (O_WR_OVERFLOW !== 1'b0) begin failures++; $display("FAIL fpp_ovf: got %0b want 0", O_WR_OVERFLOW); end
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        I_RD_REQ = 1'b1; I_RD_COL = 10'd10; I_WR_VALID = 1'b1; I_WR_PIXEL = 24'h000055;
        #1;
        checks++; if (O_RD_GNT !== 1'b1) begin failures++; $display("FAIL mid_gnt0: got %0b want 1", O_RD_GNT); end
        step();
        I_RD_COL = 10'd11;
        #1;
        checks++; if (O_RD_GNT !== 1'b1) begin failures++; $display("FAIL mid_gnt1: got %0b want 1", O_RD_GNT); end
        step();
        clear_inputs();
        #1;
        checks++; if (O_FB_RE !== 1'b1 || O_WR_LEVEL !== 3'd2) begin failures++; $display("FAIL mid_pre: got re=%0b level=%0d want 1/2", O_FB_RE, O_WR_LEVEL); end
        I_RESET  = 1'b1;
        I_RD_REQ = 1'b1;
        #1;
        checks++; if (O_FB_RE !== 1'b0 || O_FB_COL !== '0 || O_RD_GNT !== 1'b0) begin failures++; $display("FAIL mid_drop: got re=%0b col=%0d gnt=%0b want 0/0/0", O_FB_RE, O_FB_COL, O_RD_GNT); end
        checks++; if (O_WR_LEVEL !== 3'd0 || O_RD_VALID !== 1'b0) begin failures++; $display("FAIL mid_level: got level=%0d v=%0b want 0/0", O_WR_LEVEL, O_RD_VALID); end
        repeat (2) @(posedge I_CLK);
        #1;
        I_RESET  = 1'b0;
        I_RD_REQ = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if (O_RD_VALID !== 1'b0 || O_FB_WE !== 1'b0 || O_WR_LEVEL !== 3'd0) begin failures++; $display("FAIL mid_after c%0d: got v=%0b we=%0b level=%0d want 0/0/0", c, O_RD_VALID, O_FB_WE, O_WR_LEVEL); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_isolated_read();
        test_back_to_back();
        test_round_robin();
`ifdef FB_ARB_WR_URGENT_EN
        test_urgent_rate();
`else
        test_full_push_pop();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
